// File: rtl/taiko_pkg.sv
// Shared types for the note-chart sequencer: run states, tick phases and the
// per-note slot record used by the scroll table and the scheduler.
package taiko_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PH_WAIT  = 2'b00,
    PH_FETCH = 2'b01,
    PH_SPAWN = 2'b10,
    PH_DRAW  = 2'b11
  } phase_t;

  typedef struct packed {
    logic       active;
    logic [7:0] x;
    logic [2:0] color;
  } slot_t;

  localparam logic [2:0] COLOR_NONE = 3'd0;

endpackage

// File: rtl/note_slot_table.sv
// Fixed pool of scrolling notes: moves/retires all notes on a beat, allocates
// the lowest free entry for a new note and exposes one entry to the scanner.
module note_slot_table
  import taiko_pkg::*;
#(
  parameter int         SLOTS   = 4,
  parameter logic [7:0] X_START = 8'd159,
  parameter logic [7:0] X_HIT   = 8'd16,
  parameter logic [7:0] STEP    = 8'd4,
  parameter int         IW      = $clog2(SLOTS + 1),
  parameter int         CW      = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          move,
  input  logic          spawn,
  input  logic [2:0]    spawn_color,
  input  logic [IW-1:0] rd_idx,
  output slot_t         rd_slot,
  output logic [CW-1:0] retire_cnt,
  output logic          any_survivor,
  output logic          has_free
);

  // Retire test happens before the subtract, so x can never wrap below zero.
  localparam logic [7:0] X_RETIRE = X_HIT + STEP;

  slot_t         slots [SLOTS];
  logic [IW-1:0] free_idx;

  always_comb begin
    retire_cnt   = '0;
    any_survivor = 1'b0;
    has_free     = 1'b0;
    free_idx     = '0;
    rd_slot      = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (slots[i].active) begin
        if (slots[i].x < X_RETIRE) retire_cnt = retire_cnt + CW'(1);
        else any_survivor = 1'b1;
      end
      if (rd_idx == IW'(i)) rd_slot = slots[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (move && slots[i].active) begin
          if (slots[i].x < X_RETIRE) slots[i] <= '0;
          else slots[i].x <= slots[i].x - STEP;
        end
        if (spawn && has_free && free_idx == IW'(i)) begin
          slots[i] <= '{active: 1'b1, x: X_START, color: spawn_color};
        end
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Beat-driven sequencer: on each tick moves the notes, fetches and spawns the
// next chart entry, then hands every live note to the drawing stage by req/ack.
module note_scheduler
  import taiko_pkg::*;
#(
  parameter int         BEATS   = 160,
  parameter int         SLOTS   = 4,
  parameter logic [7:0] X_START = 8'd159,
  parameter logic [7:0] X_HIT   = 8'd16,
  parameter logic [7:0] STEP    = 8'd4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  output logic [7:0] chart_addr,
  input  logic [2:0] chart_data,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [7:0] draw_x,
  output logic [2:0] draw_color,
  output logic [7:0] beat,
  output logic [1:0] state,
  output logic       expired,
  output logic       overflow,
  output logic       tick_lost
);

  localparam int IW = $clog2(SLOTS + 1);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int EW = CW + 1;

  state_t        st, st_n;
  phase_t        ph, ph_n;
  logic [7:0]    beat_n, addr_n, x_n;
  logic [2:0]    col_n;
  logic [IW-1:0] idx, idx_n;
  logic          req_n, pending, pend_n, ovf_n, lost_n;
  logic [EW-1:0] exp_cnt, exp_n;
  logic          tbl_clear, tbl_move, tbl_spawn;
  slot_t         rd_slot;
  logic [CW-1:0] retire_cnt;
  logic          any_survivor, has_free;

  note_slot_table #(
    .SLOTS(SLOTS), .X_START(X_START), .X_HIT(X_HIT), .STEP(STEP), .IW(IW), .CW(CW)
  ) u_table (
    .clk          (CLOCK_50),
    .rst_n        (resetn),
    .clear        (tbl_clear),
    .move         (tbl_move),
    .spawn        (tbl_spawn),
    .spawn_color  (chart_data),
    .rd_idx       (idx),
    .rd_slot      (rd_slot),
    .retire_cnt   (retire_cnt),
    .any_survivor (any_survivor),
    .has_free     (has_free)
  );

  assign state   = st;
  // Retirements queue up so several at once become back-to-back pulses.
  assign expired = (exp_cnt != '0);

  always_comb begin
    st_n      = st;
    ph_n      = ph;
    beat_n    = beat;
    addr_n    = chart_addr;
    idx_n     = idx;
    req_n     = draw_req;
    x_n       = draw_x;
    col_n     = draw_color;
    pend_n    = pending;
    exp_n     = exp_cnt;
    ovf_n     = 1'b0;
    lost_n    = 1'b0;
    tbl_clear = 1'b0;
    tbl_move  = 1'b0;
    tbl_spawn = 1'b0;
    if (exp_cnt != '0) exp_n = exp_cnt - EW'(1);

    case (st)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          st_n      = ST_PLAY;
          ph_n      = PH_WAIT;
          beat_n    = 8'd0;
          idx_n     = '0;
          req_n     = 1'b0;
          pend_n    = 1'b0;
          tbl_clear = 1'b1;
        end
      end
      default: begin
        if (ph != PH_WAIT && tick) begin
          if (pending) lost_n = 1'b1;
          else pend_n = 1'b1;
        end
        case (ph)
          PH_WAIT: begin
            if (tick || pending) begin
              tbl_move = 1'b1;
              exp_n    = exp_n + EW'(retire_cnt);
              pend_n   = tick && pending;
              idx_n    = '0;
              if (st == ST_PLAY && beat != 8'(BEATS - 1)) begin
                addr_n = beat;
                beat_n = beat + 8'd1;
                ph_n   = PH_FETCH;
              end else if (st == ST_PLAY) begin
                st_n = ST_DRAIN;
                ph_n = PH_DRAW;
              end else if (!any_survivor) begin
                st_n = ST_DONE;
              end else begin
                ph_n = PH_DRAW;
              end
            end
          end
          PH_FETCH: ph_n = PH_SPAWN;
          PH_SPAWN: begin
            if (chart_data != COLOR_NONE) begin
              if (has_free) tbl_spawn = 1'b1;
              else ovf_n = 1'b1;
            end
            ph_n = PH_DRAW;
          end
          default: begin
            // A request drops for at least one cycle before the next one rises.
            if (draw_req) begin
              if (draw_ack) begin
                req_n = 1'b0;
                idx_n = idx + IW'(1);
              end
            end else if (idx == IW'(SLOTS)) begin
              ph_n = PH_WAIT;
            end else if (rd_slot.active) begin
              req_n = 1'b1;
              x_n   = rd_slot.x;
              col_n = rd_slot.color;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st         <= ST_IDLE;
      ph         <= PH_WAIT;
      beat       <= 8'd0;
      chart_addr <= 8'd0;
      idx        <= '0;
      draw_req   <= 1'b0;
      draw_x     <= 8'd0;
      draw_color <= 3'd0;
      pending    <= 1'b0;
      exp_cnt    <= '0;
      overflow   <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      st         <= st_n;
      ph         <= ph_n;
      beat       <= beat_n;
      chart_addr <= addr_n;
      idx        <= idx_n;
      draw_req   <= req_n;
      draw_x     <= x_n;
      draw_color <= col_n;
      pending    <= pend_n;
      exp_cnt    <= exp_n;
      overflow   <= ovf_n;
      tick_lost  <= lost_n;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: chart ROM model, auto-acking draw stage
// and pulse counters, with hand-computed expectations per scenario.
module tb_note_scheduler;

  localparam int BEATS = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic       tick     = 1'b0;
  logic       draw_ack = 1'b0;
  logic [7:0] chart_addr, draw_x, beat;
  logic [2:0] chart_data, draw_color;
  logic       draw_req, expired, overflow, tick_lost;
  logic [1:0] state;

  logic [2:0] rom [BEATS];
  int n_checks = 0, n_fail = 0;
  int exp_count = 0, ovf_count = 0, lost_count = 0;
  int hold_cnt = 0, ack_delay = 0, req_len = 0;
  bit ack_en = 1'b1;
  logic [7:0] rise_x;
  logic [7:0] drawn_x [$];
  logic [2:0] drawn_c [$];

  note_scheduler #(.BEATS(BEATS)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .tick       (tick),
    .chart_addr (chart_addr),
    .chart_data (chart_data),
    .draw_req   (draw_req),
    .draw_ack   (draw_ack),
    .draw_x     (draw_x),
    .draw_color (draw_color),
    .beat       (beat),
    .state      (state),
    .expired    (expired),
    .overflow   (overflow),
    .tick_lost  (tick_lost)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) chart_data <= rom[chart_addr[2:0]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Drawing stage model and pulse counters, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    exp_count  += int'(expired);
    ovf_count  += int'(overflow);
    lost_count += int'(tick_lost);
    if (draw_req) begin
      if (!draw_ack) begin
        if (hold_cnt == 0) rise_x = draw_x;
        hold_cnt++;
        if (ack_en && hold_cnt > ack_delay) begin
          draw_ack = 1'b1;
          req_len  = hold_cnt;
          drawn_x.push_back(draw_x);
          drawn_c.push_back(draw_color);
          checkOutput("req_hold_x", draw_x, rise_x);
        end
      end
    end else begin
      draw_ack = 1'b0;
      hold_cnt = 0;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic applyStimulus(input bit do_start, input bit do_tick);
    @(posedge CLOCK_50);
    #2;
    start = do_start;
    tick  = do_tick;
    @(posedge CLOCK_50);
    #2;
    start = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic clearLog();
    drawn_x.delete();
    drawn_c.delete();
    exp_count  = 0;
    ovf_count  = 0;
    lost_count = 0;
  endtask

  task automatic doReset();
    @(posedge CLOCK_50);
    #2;
    resetn = 1'b0;
    waitCycles(2);
    resetn = 1'b1;
    waitCycles(1);
  endtask

  task automatic loadChart(input logic [2:0] c0, c1, c2, c3, c4);
    for (int i = 0; i < BEATS; i++) rom[i] = 3'd0;
    rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3; rom[4] = c4;
  endtask

  initial begin
    loadChart(3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    waitCycles(3);
    checkOutput("reset_state", state, 2'b00);
    checkOutput("reset_req", draw_req, 1'b0);
    checkOutput("reset_beat", beat, 8'd0);
    checkOutput("reset_expired", expired, 1'b0);
    resetn = 1'b1;

    // Reset in the middle of a held draw request
    ack_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_play", state, 2'b01);
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    checkOutput("pre_rst_req", draw_req, 1'b1);
    checkOutput("pre_rst_beat", beat, 8'd1);
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_req", draw_req, 1'b0);
    checkOutput("async_rst_state", state, 2'b00);
    checkOutput("async_rst_beat", beat, 8'd0);
    checkOutput("async_rst_addr", chart_addr, 8'd0);
    waitCycles(1);
    checkOutput("rst_hold_state", state, 2'b00);
    resetn = 1'b1;
    ack_en = 1'b1;
    waitCycles(2);

    // Single note, ack delayed by three cycles
    doReset();
    clearLog();
    ack_delay = 3;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_addr", chart_addr, 8'd0);
    checkOutput("t1_beat", beat, 8'd1);
    waitCycles(1);
    checkOutput("t2_no_req", draw_req, 1'b0);
    waitCycles(30);
    checkOutput("one_n_draws", drawn_x.size(), 1);
    if (drawn_x.size() > 0) begin
      checkOutput("one_x", drawn_x[0], 8'd159);
      checkOutput("one_color", drawn_c[0], 3'd5);
    end
    checkOutput("one_req_len", req_len, 4);

    // Four notes fill the table, the fifth overflows
    doReset();
    ack_delay = 0;
    loadChart(3'd1, 3'd2, 3'd3, 3'd4, 3'd6);
    applyStimulus(1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      clearLog();
      applyStimulus(1'b0, 1'b1);
      if (t == 1) checkOutput("t2_addr", chart_addr, 8'd1);
      waitCycles(40);
    end
    checkOutput("fill_ovf", ovf_count, 0);
    checkOutput("fill_n_draws", drawn_x.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < drawn_x.size()) begin
        checkOutput($sformatf("fill_x%0d", i), drawn_x[i], 147 + 4 * i);
        checkOutput($sformatf("fill_c%0d", i), drawn_c[i], i + 1);
      end
    end
    clearLog();
    applyStimulus(1'b0, 1'b1);
    waitCycles(40);
    checkOutput("ovf_pulses", ovf_count, 1);
    checkOutput("ovf_n_draws", drawn_x.size(), 4);
    if (drawn_x.size() > 0) checkOutput("ovf_x0", drawn_x[0], 8'd143);
    if (drawn_x.size() > 3) checkOutput("ovf_x3", drawn_x[3], 8'd155);

    // One note scrolls to the hit line, chart runs out into DRAIN then DONE
    doReset();
    loadChart(3'd7, 3'd0, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 36; k++) begin
      clearLog();
      applyStimulus(1'b0, 1'b1);
      waitCycles(40);
      checkOutput($sformatf("scroll_n_%0d", k), drawn_x.size(), 1);
      if (drawn_x.size() > 0) checkOutput($sformatf("scroll_x_%0d", k), drawn_x[0], 159 - 4 * k);
      checkOutput($sformatf("scroll_exp_%0d", k), exp_count, 0);
      if (k == 6) begin
        checkOutput("last_play_state", state, 2'b01);
        checkOutput("last_play_beat", beat, 8'd7);
      end
      if (k == 7) checkOutput("drain_state", state, 2'b10);
    end
    clearLog();
    applyStimulus(1'b0, 1'b1);
    waitCycles(40);
    checkOutput("retire_expired", exp_count, 1);
    checkOutput("retire_no_draw", drawn_x.size(), 0);
    checkOutput("done_state", state, 2'b11);
    checkOutput("done_beat", beat, 8'd7);
    clearLog();
    applyStimulus(1'b0, 1'b1);
    waitCycles(10);
    checkOutput("done_tick_state", state, 2'b11);
    checkOutput("done_tick_lost", lost_count, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_state", state, 2'b01);
    checkOutput("restart_beat", beat, 8'd0);

    // Ticks arriving during a stalled draw
    doReset();
    loadChart(3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    clearLog();
    ack_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b1);
    waitCycles(3);
    checkOutput("pending_no_lost", lost_count, 0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(3);
    checkOutput("second_lost", lost_count, 1);
    checkOutput("stall_beat", beat, 8'd1);
    ack_en = 1'b1;
    waitCycles(60);
    checkOutput("pend_n_draws", drawn_x.size(), 2);
    if (drawn_x.size() > 1) begin
      checkOutput("pend_x0", drawn_x[0], 8'd159);
      checkOutput("pend_x1", drawn_x[1], 8'd155);
    end
    checkOutput("pend_beat", beat, 8'd2);
    checkOutput("pend_lost_total", lost_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequences the note-chart datapath on the 4 Hz beat. On each beat tick it fetches the next chart entry, spawns the note into a free scroll slot, advances every active note toward the hit line, and feeds each live note's X position and colour, one at a time, to the drawing stage over a req/ack handshake. It replaces the free-running 160-step counter that currently drives the note list and adds run control: start, drain and done.

## Interface
- BEATS, 160: chart length in ticks; the beat counter runs 0..BEATS-1.
- SLOTS, 4: number of concurrently active notes.
- X_START, 8'd159: spawn X position.
- X_HIT, 8'd16: hit line; a note retires once it would fall below this.
- STEP, 8'd4: pixels moved per tick.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts or restarts the chart from IDLE or DONE.
- tick  in  1  one-cycle beat enable (4 Hz).
- chart_addr  out  8  chart ROM address, registered.
- chart_data  in  3  note colour from a synchronous ROM, valid the cycle after chart_addr changes; 0 means no note.
- draw_req  out  1  drawing request.
- draw_ack  in  1  drawing acknowledge.
- draw_x  out  8  X position of the note being drawn.
- draw_color  out  3  colour of the note being drawn.
- beat  out  8  current beat index.
- state  out  2  IDLE=00, PLAY=01, DRAIN=10, DONE=11.
- expired  out  1  one-cycle pulse per retired note.
- overflow  out  1  one-cycle pulse when a note is dropped because no slot is free.
- tick_lost  out  1  one-cycle pulse when a tick arrives while another tick is already pending.

## Operation
- All outputs, slots, the pending flag and the phase reset to 0; state resets to IDLE. Reset is asynchronous and can occur mid-operation: everything clears immediately and draw_req drops without waiting for ack.
- IDLE→PLAY on start: beat=0, all slots freed. DONE→PLAY on start behaves the same. A start pulse in PLAY or DRAIN is ignored.
- Tick phases (PLAY/DRAIN) run in order MOVE → FETCH → SPAWN → DRAW → WAIT.
- **MOVE** (the cycle tick is accepted):
  - Every active slot whose x < X_HIT+STEP is freed and pulses expired. If several slots retire together, expired stays high for one cycle per retired slot on consecutive cycles; the order does not matter.
  - Every other active slot does x -= STEP.
  - In PLAY: chart_addr <= beat, then beat <= beat+1.
  - If beat was BEATS-1: beat holds, state → DRAIN, and no fetch happens.
- **FETCH**: wait one cycle for the ROM.
- **SPAWN** (PLAY only): if chart_data ≠ 0, the lowest-index free slot gets x=X_START and color=chart_data. If no slot is free, the note is dropped and overflow pulses.
- **DRAW**: scan slots in ascending index. For each active slot, assert draw_req with draw_x/draw_color and hold all three stable until draw_ack is sampled high, then deassert for ≥1 cycle before the next request. Free slots are skipped with no request.
- **WAIT**: idle until the next tick.
- Tick arriving while not in WAIT: latch it into a one-deep pending flag and start MOVE right after DRAW finishes. A second tick while pending is set is discarded and pulses tick_lost.
- DRAIN: MOVE/DRAW only, no spawns. When no slot is active after MOVE, state → DONE and the DRAW scan is skipped.
- Width rules: x is unsigned 8-bit and the retire check runs before the subtract, so x never wraps. beat saturates at BEATS-1.
- tick in IDLE or DONE is ignored (no pending latch, no tick_lost).

## Timing
- Tick at cycle T: slot move/retire and chart_addr update at the T edge; chart_data valid during T+2; spawn at the T+2 edge; first draw_req no earlier than T+3.
- draw_ack may arrive in the same cycle draw_req rises; the minimum request is one cycle.
- Worst-case tick service time is 3 + SLOTS×(2 + ack latency) cycles; this is far below the 12.5 M-cycle tick period.

## Structure
- Shared package `taiko_pkg` holds:
  - state encodings (ST_IDLE..ST_DONE) and phase encodings;
  - the slot record typedef: active, x[7:0], color[2:0];
  - the colour code for no note (3'd0).
- One natural sub-module, `note_slot_table`: SLOTS entries with move/retire, lowest-free allocate, and indexed read for the scanner. The FSM, beat counter and draw handshake stay in `note_scheduler`.

## Test plan
- Reset mid-DRAW with draw_req high, then release → state=00, draw_req=0, beat=0, chart_addr=0 in the cycle after resetn falls.
- start, chart[0]=3'd5, one tick → chart_addr=0 at T+1; slot0 x=159 color=5 at T+3; one draw_req with draw_x=159, draw_color=5, held through 3 cycles of ack delay.
- Notes on four consecutive beats, SLOTS=4, a fifth note on the next beat → exactly one overflow pulse; four draw requests per tick with x spaced by 4.
- Single note, repeated ticks → x goes 159, 155, …, 19; at the next tick expired pulses and no draw_req is issued.
- BEATS=4, one note at beat 3 → state 01→10 on the 4th tick; after retirement state=11, beat=3; a following start returns state to 01 with beat=0.
- Hold draw_ack low and send two ticks → first tick latched pending, second pulses tick_lost; after ack, exactly one extra MOVE is applied.
